// File: rtl/ray_hit_error_monitor.sv
// ray_hit_error_monitor: pairs golden ray/box hit bits with a DUT's delayed hit_miss and counts per-lane misses.
module ray_hit_error_monitor #(
    parameter int LANES    = 1,
    parameter int LATENCY  = 38,
    parameter int CNT_W    = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [SAMPLE_W-1:0]    i_num_samples,
    input  logic                   i_in_valid,
    input  logic [LANES-1:0]       i_ref_hit,
    input  logic [LANES-1:0]       i_dut_hit,
    output logic [LANES*CNT_W-1:0] o_type1_cnt,
    output logic [LANES*CNT_W-1:0] o_type2_cnt,
    output logic [SAMPLE_W-1:0]    o_checked_cnt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_sat
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t r_state, w_state_nx;
    logic [SAMPLE_W-1:0] r_num, r_issued, r_checked, w_issued_nx, w_checked_nx;
    logic r_vld [LATENCY];
    logic [LANES-1:0] r_ref [LATENCY];
    logic [CNT_W-1:0] r_t1 [LANES];
    logic [CNT_W-1:0] r_t2 [LANES];
    logic [CNT_W-1:0] w_t1_nx [LANES];
    logic [CNT_W-1:0] w_t2_nx [LANES];
    logic r_sat, w_sat_nx, w_start, w_push, w_cmp;
    always_comb begin
        w_start      = i_start && (r_state == IDLE || r_state == DONE);
        w_push       = i_in_valid && r_state == RUN;
        // The oldest delay-line slot lines up with the DUT output of the same edge.
        w_cmp        = r_vld[LATENCY-1] && (r_state == RUN || r_state == DRAIN);
        w_issued_nx  = r_issued + SAMPLE_W'(w_push);
        w_checked_nx = r_checked + SAMPLE_W'(w_cmp);
        w_sat_nx     = r_sat;
        for (int l = 0; l < LANES; l++) begin
            w_t1_nx[l] = (w_cmp && r_ref[LATENCY-1][l] && !i_dut_hit[l] && r_t1[l] != '1) ? r_t1[l] + 1'b1 : r_t1[l];
            w_t2_nx[l] = (w_cmp && !r_ref[LATENCY-1][l] && i_dut_hit[l] && r_t2[l] != '1) ? r_t2[l] + 1'b1 : r_t2[l];
            w_sat_nx   = w_sat_nx || w_t1_nx[l] == '1 || w_t2_nx[l] == '1;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE, DONE: w_state_nx = w_start ? (i_num_samples == '0 ? DONE : RUN) : r_state;
            RUN:        w_state_nx = (w_push && w_issued_nx == r_num) ? DRAIN : RUN;
            DRAIN:      w_state_nx = (w_checked_nx == r_num) ? DONE : DRAIN;
            default:    w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_nx;
    always_ff @(posedge clk) begin
        if (rst)
            r_num <= '0;
        else if (w_start)
            r_num <= i_num_samples;
    end
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_issued  <= '0;
            r_checked <= '0;
            r_sat     <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_ref[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                r_t1[l] <= '0;
                r_t2[l] <= '0;
            end
        end else begin
            r_issued  <= w_issued_nx;
            r_checked <= w_checked_nx;
            r_sat     <= w_sat_nx;
            r_vld[0]  <= w_push;
            r_ref[0]  <= i_ref_hit;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_ref[i] <= r_ref[i-1];
            end
            for (int l = 0; l < LANES; l++) begin
                r_t1[l] <= w_t1_nx[l];
                r_t2[l] <= w_t2_nx[l];
            end
        end
    end
    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign o_type1_cnt[g*CNT_W +: CNT_W] = r_t1[g];
        assign o_type2_cnt[g*CNT_W +: CNT_W] = r_t2[g];
    end
    assign o_checked_cnt = r_checked;
    assign o_busy        = r_state == RUN || r_state == DRAIN;
    assign o_done        = r_state == DONE;
    assign o_sat         = r_sat;
endmodule

// File: tb/tb_ray_hit_error_monitor.sv
// tb_ray_hit_error_monitor: directed vector table plus randomized runs against a queue-based reference model.
module tb_ray_hit_error_monitor;
    localparam int LANES = 3, LAT = 4, CW = 3, SW = 8, MAXV = (1 << CW) - 1;
    localparam int PW = LANES * CW;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, iv = 1'b0;
    logic [SW-1:0] num = '0;
    logic [LANES-1:0] rf = '0, dh = '0;
    logic [PW-1:0] t1, t2;
    logic [SW-1:0] ck;
    logic busy, done, sat;
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    ray_hit_error_monitor #(.LANES(LANES), .LATENCY(LAT), .CNT_W(CW), .SAMPLE_W(SW)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_num_samples(num), .i_in_valid(iv),
        .i_ref_hit(rf), .i_dut_hit(dh), .o_type1_cnt(t1), .o_type2_cnt(t2),
        .o_checked_cnt(ck), .o_busy(busy), .o_done(done), .o_sat(sat)
    );

    typedef struct {
        logic st; logic [SW-1:0] num; logic iv; logic [LANES-1:0] rf, dh;
        logic [PW-1:0] t1, t2; logic [SW-1:0] ck; logic busy, done, sat;
    } vec_t;
    vec_t tbl [23];

    function automatic vec_t v(input int s, n, i, r, d, a, b, c, bz, dn, st);
        vec_t x;
        x.st = 1'(s); x.num = SW'(n); x.iv = 1'(i); x.rf = LANES'(r); x.dh = LANES'(d);
        x.t1 = PW'(a); x.t2 = PW'(b); x.ck = SW'(c); x.busy = 1'(bz); x.done = 1'(dn); x.sat = 1'(st);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [PW-1:0] e1, e2, input logic [SW-1:0] ec,
                           input logic eb, ed, es);
        chk({tag, " type1"}, 32'(t1), 32'(e1));
        chk({tag, " type2"}, 32'(t2), 32'(e2));
        chk({tag, " checked"}, 32'(ck), 32'(ec));
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        chk({tag, " done"}, 32'(done), 32'(ed));
        chk({tag, " sat"}, 32'(sat), 32'(es));
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: each accepted ray is due for comparison LAT edges after issue; counts are clamped totals.
    task automatic run_rand(input int n, input int pct, input bit all_t1);
        int due[$];
        logic [LANES-1:0] pref[$];
        logic [LANES-1:0] lr;
        int raw1[LANES], raw2[LANES];
        int issued = 0, checked = 0, e = 1;
        bit mdone, esat;
        logic [PW-1:0] e1, e2;
        for (int l = 0; l < LANES; l++) begin raw1[l] = 0; raw2[l] = 0; end
        start = 1'b1; num = SW'(n); iv = 1'b1; rf = '1; dh = '1;
        step;
        start = 1'b0;
        mdone = (n == 0);
        chk_all($sformatf("rand n=%0d start", n), '0, '0, '0, !mdone, mdone, 1'b0);
        while (!mdone && e < 400) begin
            iv = int'($urandom_range(0, 99)) < pct;
            rf = all_t1 ? '1 : LANES'($urandom);
            dh = all_t1 ? '0 : LANES'($urandom);
            start = $urandom_range(0, 7) == 0;
            num = SW'($urandom);
            if (due.size() > 0 && due[0] == e) begin
                void'(due.pop_front());
                lr = pref.pop_front();
                checked++;
                for (int l = 0; l < LANES; l++) begin
                    raw1[l] += int'(lr[l] & ~dh[l]);
                    raw2[l] += int'(~lr[l] & dh[l]);
                end
            end
            if (iv && issued < n) begin
                due.push_back(e + LAT);
                pref.push_back(rf);
                issued++;
            end
            mdone = (checked == n);
            step;
            start = 1'b0;
            esat = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                e1[l*CW +: CW] = CW'(raw1[l] > MAXV ? MAXV : raw1[l]);
                e2[l*CW +: CW] = CW'(raw2[l] > MAXV ? MAXV : raw2[l]);
                esat |= raw1[l] >= MAXV || raw2[l] >= MAXV;
            end
            chk_all($sformatf("rand n=%0d e=%0d", n, e), e1, e2, SW'(checked), !mdone, mdone, esat);
            e++;
        end
        if (!mdone) chk("drain_bound", 32'(done), 32'd1);
        for (int h = 0; h < 2; h++) begin
            iv = 1'b1; rf = LANES'($urandom); dh = LANES'($urandom);
            step;
            chk({"hold ", $sformatf("n=%0d", n), " checked"}, 32'(ck), 32'(n));
            chk("hold done", 32'(done), 32'd1);
        end
    endtask

    initial begin
        tbl[0]  = v(1, 4, 0, 'o0, 'o0, 'o0,   'o0,   0, 1, 0, 0);
        tbl[1]  = v(0, 0, 1, 'o5, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[2]  = v(1, 1, 1, 'o1, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[3]  = v(0, 0, 1, 'o4, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[4]  = v(0, 0, 1, 'o0, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[5]  = v(0, 0, 0, 'o0, 'o5, 'o0,   'o0,   1, 1, 0, 0);
        tbl[6]  = v(0, 0, 0, 'o0, 'o4, 'o001, 'o100, 2, 1, 0, 0);
        tbl[7]  = v(0, 0, 0, 'o0, 'o1, 'o101, 'o101, 3, 1, 0, 0);
        tbl[8]  = v(0, 0, 0, 'o0, 'o0, 'o101, 'o101, 4, 0, 1, 0);
        tbl[9]  = v(0, 0, 1, 'o7, 'o7, 'o101, 'o101, 4, 0, 1, 0);
        tbl[10] = v(1, 0, 0, 'o0, 'o0, 'o0,   'o0,   0, 0, 1, 0);
        tbl[11] = v(0, 0, 1, 'o7, 'o7, 'o0,   'o0,   0, 0, 1, 0);
        tbl[12] = v(1, 3, 0, 'o0, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[13] = v(0, 0, 1, 'o0, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[14] = v(0, 0, 0, 'o0, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[15] = v(0, 0, 1, 'o0, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[16] = v(0, 0, 0, 'o0, 'o7, 'o0,   'o0,   0, 1, 0, 0);
        tbl[17] = v(0, 0, 1, 'o0, 'o7, 'o0,   'o111, 1, 1, 0, 0);
        tbl[18] = v(1, 1, 1, 'o7, 'o7, 'o0,   'o111, 1, 1, 0, 0);
        tbl[19] = v(0, 0, 0, 'o0, 'o7, 'o0,   'o222, 2, 1, 0, 0);
        tbl[20] = v(0, 0, 1, 'o0, 'o7, 'o0,   'o222, 2, 1, 0, 0);
        tbl[21] = v(0, 0, 0, 'o0, 'o7, 'o0,   'o333, 3, 0, 1, 0);
        tbl[22] = v(0, 0, 1, 'o7, 'o0, 'o0,   'o333, 3, 0, 1, 0);
        step;
        step;
        chk_all("reset", '0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        foreach (tbl[i]) begin
            start = tbl[i].st; num = tbl[i].num; iv = tbl[i].iv; rf = tbl[i].rf; dh = tbl[i].dh;
            step;
            chk_all($sformatf("vec%0d", i), tbl[i].t1, tbl[i].t2, tbl[i].ck, tbl[i].busy, tbl[i].done, tbl[i].sat);
        end
        start = 1'b0;
        run_rand(10, 100, 1'b1);
        chk("sat type1", 32'(t1), 32'(9'o777));
        chk("sat flag", 32'(sat), 32'd1);
        chk("sat checked", 32'(ck), 32'd10);
        start = 1'b1; num = 8'd8; iv = 1'b0;
        step;
        start = 1'b0; iv = 1'b1; rf = '1; dh = '0;
        for (int k = 0; k < 6; k++) step;
        chk("mid type1", 32'(t1), 32'(9'o222));
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk_all("mid reset", '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step;
        step;
        chk_all("idle ignore", '0, '0, '0, 1'b0, 1'b0, 1'b0);
        run_rand(5, 70, 1'b0);
        for (int r = 0; r < 25; r++) run_rand(int'($urandom_range(0, 20)), int'($urandom_range(30, 100)), 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
